// File: rtl/player_hit_controller_pkg.sv
// Shared game types: player state encoding, HP and per-frame overlap widths.
// Also holds the clamped HP subtraction used when a hit registers.
package player_hit_controller_pkg;

    localparam int HP_W  = 8;
    localparam int CNT_W = 12;
    localparam int IFR_W = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_e;

    // Unsigned subtraction that floors at zero instead of wrapping.
    function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp, input int dmg);
        if (int'(hp) > dmg)
            hp_after_hit = HP_W'(int'(hp) - dmg);
        else
            hp_after_hit = '0;
    endfunction

endpackage

// File: rtl/player_hit_controller_overlap.sv
// Saturating per-frame overlap pixel counter; clear has priority over inc,
// so the pixel on a clear cycle is dropped. Count is registered (1-cycle latency).
module frame_overlap_counter
    import player_hit_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (inc && (count_q != CNT_MAX))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/player_hit_controller.sv
// Player hit/HP/invulnerability FSM evaluated once per frame_tick; all outputs registered.
// PLAYER_HIT_GODMODE_EN: hits still pulse and grant i-frames, but HP never drops and DEAD is unreachable.
module player_hit_controller
    import player_hit_controller_pkg::*;
#(
    parameter int HP_INIT       = 92,
    parameter int DAMAGE        = 1,
    parameter int IFRAMES       = 30,
    parameter int HIT_PIXEL_MIN = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_tick,
    input  logic            blank,
    input  logic            player_render,
    input  logic            object_trigger_signal,
    input  logic            restart,
    output logic            is_trigger_player,
    output logic [HP_W-1:0] hp,
    output logic            hit_pulse,
    output logic            game_over
);

    localparam logic [HP_W-1:0]  HP_RST   = HP_W'(HP_INIT);
    localparam logic [IFR_W-1:0] IFR_LOAD = IFR_W'(IFRAMES);
    localparam logic [CNT_W-1:0] MIN_PIX  = CNT_W'(HIT_PIXEL_MIN);

    state_e           state_q, state_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [IFR_W-1:0] ifr_q, ifr_d;
    logic             hit_q, hit_d;
    logic             inv_q, go_q;
    logic [CNT_W-1:0] overlap_cnt;
    logic             restart_take;
    logic             overlap;

    assign restart_take = restart && (state_q == ST_DEAD);
    assign overlap      = !blank && player_render && object_trigger_signal;

    frame_overlap_counter u_overlap (
        .clk   (clk),
        .reset (reset),
        .clear (frame_tick || restart_take),
        .inc   (overlap),
        .count (overlap_cnt)
    );

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        ifr_d   = ifr_q;
        hit_d   = 1'b0;
        // Restart beats a coincident frame_tick, so no hit is judged that cycle.
        if (restart_take) begin
            state_d = ST_ALIVE;
            hp_d    = HP_RST;
            ifr_d   = '0;
        end else if (frame_tick) begin
            case (state_q)
                ST_ALIVE: begin
                    if (overlap_cnt >= MIN_PIX) begin
                        hit_d = 1'b1;
`ifdef PLAYER_HIT_GODMODE_EN
                        state_d = ST_INVULN;
                        ifr_d   = IFR_LOAD;
`else
                        hp_d = hp_after_hit(hp_q, DAMAGE);
                        if (hp_d == '0) begin
                            state_d = ST_DEAD;
                        end else begin
                            state_d = ST_INVULN;
                            ifr_d   = IFR_LOAD;
                        end
`endif
                    end
                end
                ST_INVULN: begin
                    ifr_d = ifr_q - 1'b1;
                    if (ifr_q == IFR_W'(1))
                        state_d = ST_ALIVE;
                end
                ST_DEAD: state_d = ST_DEAD;
                default: state_d = ST_ALIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_ALIVE;
            hp_q    <= HP_RST;
            ifr_q   <= '0;
            hit_q   <= 1'b0;
            inv_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            ifr_q   <= ifr_d;
            hit_q   <= hit_d;
            inv_q   <= (state_q == ST_INVULN);
            go_q    <= (state_q == ST_DEAD);
        end
    end

    assign is_trigger_player = inv_q;
    assign hp                = hp_q;
    assign hit_pulse         = hit_q;
    assign game_over         = go_q;

endmodule

// File: doc/player_hit_controller.md
PLAYER_HIT_CONTROLLER -- requirements
Module: player_hit_controller

Interface
REQ-001 SHALL have parameter HP_INIT, default 92, player HP loaded at reset and restart.
REQ-002 SHALL have parameter DAMAGE, default 1, HP removed per registered hit.
REQ-003 SHALL have parameter IFRAMES, default 30, invulnerability length in frames, range 1..255.
REQ-004 SHALL have parameter HIT_PIXEL_MIN, default 4, overlapping pixels per frame needed to register a hit, range 1..4095.
REQ-005 SHALL have port clk, input, 1, pixel clock.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port frame_tick, input, 1, one-cycle pulse at the start of vertical blanking.
REQ-008 SHALL have port blank, input, 1, high outside the visible area.
REQ-009 SHALL have port player_render, input, 1, current pixel belongs to the player sprite.
REQ-010 SHALL have port object_trigger_signal, input, 1, current pixel belongs to a damaging object.
REQ-011 SHALL have port restart, input, 1, request to leave the game-over state.
REQ-012 SHALL have port is_trigger_player, output, 1, high while the player is invulnerable; drives the renderer.
REQ-013 SHALL have port hp, output, 8, current HP.
REQ-014 SHALL have port hit_pulse, output, 1, one-cycle pulse per registered hit.
REQ-015 SHALL have port game_over, output, 1, high in the DEAD state.

Function
REQ-016 SHALL count overlap per cycle as !blank && player_render && object_trigger_signal, in a 12-bit counter that saturates at 4095.
REQ-017 SHALL evaluate the counter on a frame_tick cycle and clear it to 0 in that same cycle; the frame_tick-cycle pixel SHALL be discarded.
REQ-018 SHALL implement states ALIVE, INVULN and DEAD; all transitions SHALL happen only on frame_tick, except restart.
REQ-019 In ALIVE, on frame_tick with count >= HIT_PIXEL_MIN: hp <= max(hp-DAMAGE, 0), hit_pulse high the next cycle for exactly one cycle; go to DEAD if the new hp is 0, else go to INVULN with iframe counter = IFRAMES.
REQ-020 In INVULN, each frame_tick SHALL decrement the iframe counter and ignore overlap; the transition to ALIVE SHALL occur on the tick where the counter goes 1->0.
REQ-021 DEAD SHALL be sticky and ignore overlap; restart held high in any cycle SHALL load hp=HP_INIT, clear the counters and go to ALIVE on the next clock.
REQ-022 restart outside DEAD SHALL be ignored.
REQ-023 restart and frame_tick in the same cycle while DEAD: restart SHALL win and no hit SHALL be evaluated.
REQ-024 Outputs SHALL be registered: is_trigger_player = (state==INVULN) and game_over = (state==DEAD), each valid one cycle after the state change.
REQ-025 HP arithmetic SHALL be 8-bit unsigned, clamped at 0, and never wrap.
REQ-026 HP_INIT > 255 or DAMAGE = 0 SHALL be treated as illegal; the bench SHALL flag it.

Reset
REQ-027 On reset low at a clock edge: state=ALIVE, hp=HP_INIT, overlap and iframe counters=0, hit_pulse=0, is_trigger_player=0, game_over=0.
REQ-028 Reset mid-frame or mid-invulnerability SHALL discard all accumulated overlap, and no hit_pulse SHALL follow.

Configuration
REQ-029 With PLAYER_HIT_GODMODE_EN defined: hp SHALL never decrement and DEAD SHALL be unreachable; hit_pulse and the ALIVE->INVULN sequence SHALL still occur.
REQ-030 Without PLAYER_HIT_GODMODE_EN: behaviour SHALL be exactly REQ-019.

Structure
REQ-031 The shared game package SHALL hold the state encoding (ALIVE=0, INVULN=1, DEAD=2), HP width 8 and overlap counter width 12.
REQ-032 The saturating per-frame counter SHALL be a sub-module frame_overlap_counter with ports clk, reset, clear, inc, count.

Verification
REQ-033 Defaults, 10 overlap pixels then frame_tick -> hit_pulse one cycle, hp 92->91, is_trigger_player=1.
REQ-034 3 overlap pixels (HIT_PIXEL_MIN=4) -> no hit_pulse, hp stays 92; 4 pixels -> hit.
REQ-035 After a hit, overlap on every frame for 30 frame_ticks -> hp stays 91, is_trigger_player drops on tick 30, a hit registers on tick 31.
REQ-036 HP_INIT=2, DAMAGE=5, hit -> hp=0, game_over=1; further overlap -> no hit_pulse; restart -> hp=2, game_over=0.
REQ-037 Overlap asserted only while blank=1 -> count 0, no hit.
REQ-038 With PLAYER_HIT_GODMODE_EN, 5 hits -> hp stays 92, 5 hit_pulses, game_over never 1.
